snapshot_bridge: RTL and testbench
==================================

Name: snapshot_bridge

Overview:
- Parametrised snapshot bridge between a narrow upstream reg_native_if (bus width) and a wide downstream reg_native_if (register/memory width = SLICE_NUM × bus width).
- Buffers partial slice writes and commits them as a single atomic wide write.
- Captures one atomic wide read and serves the remaining slices from that snapshot.
- Sits between a regslv decoder and an external memory or register group. Generalises fixed-ratio snapshot logic to any slice count, any entry depth, selectable trigger slices, and a downstream timeout.

Parameters:
- BUS_DATA_WIDTH, 32, upstream data width.
- SLICE_NUM, 4, bus slices per wide word; ≥2, need not be a power of two.
- SLICE_BITS, $clog2(SLICE_NUM), upstream addr bits selecting the slice.
- ENTRY_ADDR_WIDTH, 1, downstream address width; entry count is 2^ENTRY_ADDR_WIDTH.
- UP_ADDR_WIDTH, ENTRY_ADDR_WIDTH+SLICE_BITS, upstream address width.
- WR_TRIG_SLICE, 0, slice whose write commits the wide write.
- RD_TRIG_SLICE, 0, slice whose read triggers the wide read.
- TIMEOUT_CYCLES, 255, downstream ack wait limit; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, up_rd_data value returned on error.

Ports:
- clk  in  1  Single clock.
- rstn  in  1  Synchronous, active-low reset.
- up_req_vld  in  1  Upstream request, one-cycle pulse.
- up_wr_en  in  1  Upstream write qualifier.
- up_rd_en  in  1  Upstream read qualifier.
- up_addr  in  UP_ADDR_WIDTH  Upstream address: {entry, slice}.
- up_wr_data  in  BUS_DATA_WIDTH  Upstream write data.
- up_ack_vld  out  1  Upstream acknowledge, one-cycle pulse.
- up_rd_data  out  BUS_DATA_WIDTH  Upstream read data, valid with up_ack_vld.
- up_err  out  1  Error flag, pulses with up_ack_vld on timeout or bad slice.
- ds_req_vld  out  1  Downstream request, one-cycle pulse.
- ds_wr_en  out  1  Downstream write qualifier.
- ds_rd_en  out  1  Downstream read qualifier.
- ds_addr  out  ENTRY_ADDR_WIDTH  Downstream entry address.
- ds_wr_data  out  SLICE_NUM*BUS_DATA_WIDTH  Downstream wide write data.
- ds_ack_vld  in  1  Downstream acknowledge.
- ds_rd_data  in  SLICE_NUM*BUS_DATA_WIDTH  Downstream wide read data.

Behaviour:
- Reset (rstn=0 sampled at posedge clk):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Write buffer is cleared to 0.
  - Snapshot is invalid and its data is 0.
  - The timeout counter is 0.
  - Reset asserted mid-transaction abandons the transaction: no ack is issued and ds_req_vld is not re-issued.
- Address decoding:
  - Slice index s = up_addr[SLICE_BITS-1:0].
  - Entry index e = up_addr[UP_ADDR_WIDTH-1:SLICE_BITS].
  - Slice k maps to wide bits [k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH].
- FSM states:
  - IDLE: accepts a request.
  - DS_WR: waiting for the downstream write ack.
  - DS_RD: waiting for the downstream read ack.
  - ACK: drives the upstream ack.
- Error slice: s ≥ SLICE_NUM. ACK next cycle with up_err=1 and up_rd_data=ERR_DATA. No other effect.
- Write, s ≠ WR_TRIG_SLICE:
  - Store up_wr_data into buffer slice s.
  - Ack next cycle (latency 1).
  - No downstream activity.
- Write, s = WR_TRIG_SLICE:
  - ds_wr_data = buffer with slice s replaced by up_wr_data; ds_addr = e.
  - ds_req_vld and ds_wr_en pulse in the cycle after the request.
  - ds_addr and ds_wr_data hold until ds_ack_vld.
  - The up ack follows ds_ack_vld by 1 cycle.
  - The buffer keeps its contents after the commit; slices are not cleared.
  - If the snapshot is valid and its tag equals e, the snapshot is invalidated.
- Read, s = RD_TRIG_SLICE, or snapshot invalid, or snapshot tag ≠ e:
  - ds_req_vld and ds_rd_en pulse the next cycle.
  - On ds_ack_vld: latch ds_rd_data into the snapshot, set tag=e and valid=1.
  - ACK next cycle with up_rd_data = snapshot slice s.
- Read, snapshot hit: ACK next cycle with snapshot slice s. No downstream access.
- Timeout:
  - The counter runs in DS_WR and DS_RD.
  - When it reaches TIMEOUT_CYCLES without ds_ack_vld: go to ACK with up_err=1 and up_rd_data=ERR_DATA.
  - The snapshot is left unchanged.
  - A late ds_ack_vld that arrives in IDLE is ignored.
- Request qualifiers:
  - up_req_vld outside IDLE is ignored, since the upstream protocol allows one outstanding request.
  - up_wr_en has priority if both up_wr_en and up_rd_en are set.
  - A request with neither set is acked with data 0 and no error.
- Upstream outputs:
  - up_ack_vld is exactly one cycle.
  - up_rd_data is 0 on write acks.
  - up_rd_data is 0 outside ack cycles.
- ds_ack_vld arriving in the same cycle as ds_req_vld is accepted, giving zero-wait downstream.

Test Plan (BUS_DATA_WIDTH=32, SLICE_NUM=4, ENTRY_ADDR_WIDTH=1, triggers=0):
- Atomic write commit:
  - Stimulus: write slices 3,2,1 of entry 1 with 32'hFFFF_FFFF. Downstream memory changes to 0xAAAA… after slice 1. Then write slice 0 with 32'hFFFF_FFFF.
  - Response: exactly one ds write, addr 1, data 128'hFFFF…FFFF.
- Snapshot read coherence:
  - Stimulus: read slice 0 of entry 0. Memory changes to 0xAAAA… Then read slices 1–3.
  - Response: all slices return the pre-change 32'hFFFF_FFFF. Exactly one ds read.
- Snapshot miss:
  - Stimulus: read slice 2 of entry 1 with no prior snapshot.
  - Response: a ds read is issued. Data = mem[1][95:64].
- Commit invalidation:
  - Stimulus: snapshot entry 0, then commit a write to entry 0, then read slice 1 of entry 0.
  - Response: a new ds read is issued.
- Timeout:
  - Stimulus: hold ds_ack_vld=0 on a read, with TIMEOUT_CYCLES=8.
  - Response: ack with up_err=1 and up_rd_data=32'hDEAD_BEEF at cycle 8 after ds_req_vld. Snapshot stays invalid.
- Reset mid-operation:
  - Stimulus: assert rstn=0 during DS_WR.
  - Response: next cycle all outputs are 0 and no ack is issued. After release, a buffered slice reads 0 in the committed word.

Source files
------------

// File: rtl/snapshot_bridge.sv
// -----------------------------------------------------------------------------
// snapshot_bridge
//
// Bridges a narrow upstream register interface (BUS_DATA_WIDTH) onto a wide
// downstream interface (SLICE_NUM * BUS_DATA_WIDTH) so that wide registers or
// memory words are always written and read atomically.
//   - Writes to non-trigger slices are collected in a write buffer. A write
//     to WR_TRIG_SLICE commits buffer+new slice as one wide write.
//   - A read of RD_TRIG_SLICE (or any read that misses the snapshot) fetches
//     the whole wide word into a snapshot. Later slice reads of the same
//     entry are served from the snapshot without touching downstream.
//   - Downstream waits are bounded by TIMEOUT_CYCLES (0 = wait forever).
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   up_req_vld/up_wr_en/up_rd_en/up_addr/up_wr_data   upstream request
//   up_ack_vld/up_rd_data/up_err                      upstream response
//   ds_req_vld/ds_wr_en/ds_rd_en/ds_addr/ds_wr_data   downstream request
//   ds_ack_vld/ds_rd_data                             downstream response
// All outputs are registered.
// -----------------------------------------------------------------------------
module snapshot_bridge #(
  parameter int BUS_DATA_WIDTH   = 32,
  parameter int SLICE_NUM        = 4,
  parameter int SLICE_BITS       = $clog2(SLICE_NUM),
  parameter int ENTRY_ADDR_WIDTH = 1,
  parameter int UP_ADDR_WIDTH    = ENTRY_ADDR_WIDTH + SLICE_BITS,
  parameter int WR_TRIG_SLICE    = 0,
  parameter int RD_TRIG_SLICE    = 0,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter logic [BUS_DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  up_req_vld,
  input  logic                                  up_wr_en,
  input  logic                                  up_rd_en,
  input  logic [UP_ADDR_WIDTH-1:0]              up_addr,
  input  logic [BUS_DATA_WIDTH-1:0]             up_wr_data,
  output logic                                  up_ack_vld,
  output logic [BUS_DATA_WIDTH-1:0]             up_rd_data,
  output logic                                  up_err,
  output logic                                  ds_req_vld,
  output logic                                  ds_wr_en,
  output logic                                  ds_rd_en,
  output logic [ENTRY_ADDR_WIDTH-1:0]           ds_addr,
  output logic [SLICE_NUM*BUS_DATA_WIDTH-1:0]   ds_wr_data,
  input  logic                                  ds_ack_vld,
  input  logic [SLICE_NUM*BUS_DATA_WIDTH-1:0]   ds_rd_data
);

  localparam int WIDE = SLICE_NUM * BUS_DATA_WIDTH;
  // Counter only has to hold TIMEOUT_CYCLES-1; it fires on that value.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [SLICE_BITS:0]   SLICE_LIM = (SLICE_BITS + 1)'(SLICE_NUM);
  localparam logic [SLICE_BITS-1:0] WR_TRIG   = SLICE_BITS'(WR_TRIG_SLICE);
  localparam logic [SLICE_BITS-1:0] RD_TRIG   = SLICE_BITS'(RD_TRIG_SLICE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DS_WR = 2'd1,
    ST_DS_RD = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [WIDE-1:0]                wr_buf_q, wr_buf_d;
  logic [WIDE-1:0]                snap_q, snap_d;
  logic                           snap_vld_q, snap_vld_d;
  logic [ENTRY_ADDR_WIDTH-1:0]    snap_tag_q, snap_tag_d;
  logic [TO_W-1:0]                to_cnt_q, to_cnt_d;
  logic [SLICE_BITS-1:0]          pend_slice_q, pend_slice_d;

  logic                           up_ack_vld_q, up_ack_vld_d;
  logic [BUS_DATA_WIDTH-1:0]      up_rd_data_q, up_rd_data_d;
  logic                           up_err_q, up_err_d;
  logic                           ds_req_vld_q, ds_req_vld_d;
  logic                           ds_wr_en_q, ds_wr_en_d;
  logic                           ds_rd_en_q, ds_rd_en_d;
  logic [ENTRY_ADDR_WIDTH-1:0]    ds_addr_q, ds_addr_d;
  logic [WIDE-1:0]                ds_wr_data_q, ds_wr_data_d;

  logic [SLICE_BITS-1:0]          req_slice_s;
  logic [ENTRY_ADDR_WIDTH-1:0]    req_entry_s;
  logic                           slice_bad_s;
  logic                           snap_hit_s;
  logic [WIDE-1:0]                merged_s;
  logic [BUS_DATA_WIDTH-1:0]      snap_slice_s;
  logic [BUS_DATA_WIDTH-1:0]      ds_slice_s;

  assign req_slice_s = up_addr[SLICE_BITS-1:0];
  assign req_entry_s = up_addr[UP_ADDR_WIDTH-1:SLICE_BITS];
  assign slice_bad_s = ({1'b0, req_slice_s} >= SLICE_LIM);
  assign snap_hit_s  = snap_vld_q && (snap_tag_q == req_entry_s);

  // Slice-level views: write buffer with the request slice merged in, and the
  // snapshot / downstream slices addressed by the request.
  always_comb begin
    merged_s     = wr_buf_q;
    snap_slice_s = '0;
    ds_slice_s   = ds_rd_data[pend_slice_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    if (!slice_bad_s) begin
      merged_s[req_slice_s*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = up_wr_data;
      snap_slice_s = snap_q[req_slice_s*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end else begin
      merged_s     = wr_buf_q;
      snap_slice_s = '0;
    end
  end

  // Next-state, datapath and output computation.
  always_comb begin
    state_d      = state_q;
    wr_buf_d     = wr_buf_q;
    snap_d       = snap_q;
    snap_vld_d   = snap_vld_q;
    snap_tag_d   = snap_tag_q;
    to_cnt_d     = to_cnt_q;
    pend_slice_d = pend_slice_q;
    up_ack_vld_d = 1'b0;
    up_rd_data_d = '0;
    up_err_d     = 1'b0;
    ds_req_vld_d = 1'b0;
    ds_wr_en_d   = 1'b0;
    ds_rd_en_d   = 1'b0;
    ds_addr_d    = ds_addr_q;
    ds_wr_data_d = ds_wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (up_req_vld) begin
          pend_slice_d = req_slice_s;
          if (slice_bad_s) begin
            state_d      = ST_ACK;
            up_ack_vld_d = 1'b1;
            up_err_d     = 1'b1;
            up_rd_data_d = ERR_DATA;
          end else if (up_wr_en) begin
            if (req_slice_s == WR_TRIG) begin
              // Commit: the trigger slice itself is not kept in the buffer.
              state_d      = ST_DS_WR;
              ds_req_vld_d = 1'b1;
              ds_wr_en_d   = 1'b1;
              ds_addr_d    = req_entry_s;
              ds_wr_data_d = merged_s;
              to_cnt_d     = '0;
            end else begin
              wr_buf_d     = merged_s;
              state_d      = ST_ACK;
              up_ack_vld_d = 1'b1;
            end
          end else if (up_rd_en) begin
            if ((req_slice_s == RD_TRIG) || !snap_hit_s) begin
              state_d      = ST_DS_RD;
              ds_req_vld_d = 1'b1;
              ds_rd_en_d   = 1'b1;
              ds_addr_d    = req_entry_s;
              to_cnt_d     = '0;
            end else begin
              state_d      = ST_ACK;
              up_ack_vld_d = 1'b1;
              up_rd_data_d = snap_slice_s;
            end
          end else begin
            // Unqualified request: plain ack, no data, no error.
            state_d      = ST_ACK;
            up_ack_vld_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DS_WR, ST_DS_RD: begin
        if (ds_ack_vld) begin
          state_d      = ST_ACK;
          up_ack_vld_d = 1'b1;
          to_cnt_d     = '0;
          ds_addr_d    = '0;
          ds_wr_data_d = '0;
          if (state_q == ST_DS_RD) begin
            snap_d       = ds_rd_data;
            snap_vld_d   = 1'b1;
            snap_tag_d   = ds_addr_q;
            up_rd_data_d = ds_slice_s;
          end else if (snap_vld_q && (snap_tag_q == ds_addr_q)) begin
            // Committed entry makes any snapshot of it stale.
            snap_vld_d = 1'b0;
          end else begin
            snap_vld_d = snap_vld_q;
          end
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          // Timeout: snapshot untouched, error reported upstream.
          state_d      = ST_ACK;
          up_ack_vld_d = 1'b1;
          up_err_d     = 1'b1;
          up_rd_data_d = ERR_DATA;
          to_cnt_d     = '0;
          ds_addr_d    = '0;
          ds_wr_data_d = '0;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      wr_buf_q     <= '0;
      snap_q       <= '0;
      snap_vld_q   <= 1'b0;
      snap_tag_q   <= '0;
      to_cnt_q     <= '0;
      pend_slice_q <= '0;
      up_ack_vld_q <= 1'b0;
      up_rd_data_q <= '0;
      up_err_q     <= 1'b0;
      ds_req_vld_q <= 1'b0;
      ds_wr_en_q   <= 1'b0;
      ds_rd_en_q   <= 1'b0;
      ds_addr_q    <= '0;
      ds_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_buf_q     <= wr_buf_d;
      snap_q       <= snap_d;
      snap_vld_q   <= snap_vld_d;
      snap_tag_q   <= snap_tag_d;
      to_cnt_q     <= to_cnt_d;
      pend_slice_q <= pend_slice_d;
      up_ack_vld_q <= up_ack_vld_d;
      up_rd_data_q <= up_rd_data_d;
      up_err_q     <= up_err_d;
      ds_req_vld_q <= ds_req_vld_d;
      ds_wr_en_q   <= ds_wr_en_d;
      ds_rd_en_q   <= ds_rd_en_d;
      ds_addr_q    <= ds_addr_d;
      ds_wr_data_q <= ds_wr_data_d;
    end
  end

  assign up_ack_vld = up_ack_vld_q;
  assign up_rd_data = up_rd_data_q;
  assign up_err     = up_err_q;
  assign ds_req_vld = ds_req_vld_q;
  assign ds_wr_en   = ds_wr_en_q;
  assign ds_rd_en   = ds_rd_en_q;
  assign ds_addr    = ds_addr_q;
  assign ds_wr_data = ds_wr_data_q;

endmodule

// File: tb/tb_snapshot_bridge.sv
// -----------------------------------------------------------------------------
// tb_snapshot_bridge
//
// DUT "a": 32-bit bus, 4 slices, 2 entries, triggers on slice 0, timeout 8,
// driven from a vector table plus hand-written timeout / reset sequences.
// Expected upstream responses go into a scoreboard queue at request time and
// are popped when up_ack_vld appears. A behavioural downstream memory with
// configurable ack delay serves DUT "a".
// DUT "b": 3 slices, so slice index 3 exercises the error-slice path.
// -----------------------------------------------------------------------------
module tb_snapshot_bridge;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // ---------------- DUT a ----------------
  logic         up_req_vld = 1'b0, up_wr_en = 1'b0, up_rd_en = 1'b0;
  logic [2:0]   up_addr = 3'd0;
  logic [31:0]  up_wr_data = 32'd0;
  logic         up_ack_vld, up_err;
  logic [31:0]  up_rd_data;
  logic         ds_req_vld, ds_wr_en, ds_rd_en;
  logic [0:0]   ds_addr;
  logic [127:0] ds_wr_data;
  logic         ds_ack_vld;
  logic [127:0] ds_rd_data;

  snapshot_bridge #(
    .BUS_DATA_WIDTH(32), .SLICE_NUM(4), .ENTRY_ADDR_WIDTH(1),
    .WR_TRIG_SLICE(0), .RD_TRIG_SLICE(0), .TIMEOUT_CYCLES(8)
  ) u_dut_a (
    .clk(clk), .rstn(rstn),
    .up_req_vld(up_req_vld), .up_wr_en(up_wr_en), .up_rd_en(up_rd_en),
    .up_addr(up_addr), .up_wr_data(up_wr_data),
    .up_ack_vld(up_ack_vld), .up_rd_data(up_rd_data), .up_err(up_err),
    .ds_req_vld(ds_req_vld), .ds_wr_en(ds_wr_en), .ds_rd_en(ds_rd_en),
    .ds_addr(ds_addr), .ds_wr_data(ds_wr_data),
    .ds_ack_vld(ds_ack_vld), .ds_rd_data(ds_rd_data)
  );

  // ---------------- DUT b (3 slices, zero-wait downstream) ----------------
  logic        b_req = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic [2:0]  b_addr = 3'd0;
  logic [31:0] b_wdata = 32'd0;
  logic        b_ack, b_err;
  logic [31:0] b_rdata;
  logic        b_ds_req, b_ds_wr, b_ds_rd;
  logic [0:0]  b_ds_addr;
  logic [95:0] b_ds_wdata;
  logic        b_ds_ack;
  logic [95:0] b_ds_rdata;
  assign b_ds_ack   = b_ds_req;
  assign b_ds_rdata = 96'hCCCC_0002_BBBB_0001_AAAA_0000;

  snapshot_bridge #(
    .BUS_DATA_WIDTH(32), .SLICE_NUM(3), .ENTRY_ADDR_WIDTH(1), .TIMEOUT_CYCLES(8)
  ) u_dut_b (
    .clk(clk), .rstn(rstn),
    .up_req_vld(b_req), .up_wr_en(b_wr), .up_rd_en(b_rd),
    .up_addr(b_addr), .up_wr_data(b_wdata),
    .up_ack_vld(b_ack), .up_rd_data(b_rdata), .up_err(b_err),
    .ds_req_vld(b_ds_req), .ds_wr_en(b_ds_wr), .ds_rd_en(b_ds_rd),
    .ds_addr(b_ds_addr), .ds_wr_data(b_ds_wdata),
    .ds_ack_vld(b_ds_ack), .ds_rd_data(b_ds_rdata)
  );

  int b_dsreq_cnt = 0;
  always @(negedge clk) if (b_ds_req === 1'b1) b_dsreq_cnt++;

  // ---------------- downstream memory model for DUT a ----------------
  logic [127:0] mem [2];
  int  ack_dly = 1;
  bit  ack_off = 1'b0;
  bit  busy = 1'b0;
  bit  cur_wr = 1'b0;
  int  wcnt = 0;
  int  dsw_cnt = 0, dsr_cnt = 0;
  logic [0:0]   last_waddr = 1'b0;
  logic [127:0] last_wdata = 128'd0;

  initial begin
    ds_ack_vld = 1'b0;
    ds_rd_data = 128'd0;
    forever begin
      @(negedge clk);
      ds_ack_vld = 1'b0;
      ds_rd_data = 128'd0;
      if (!rstn) begin
        busy = 1'b0;
      end else begin
        if (ds_req_vld === 1'b1) begin
          busy   = !ack_off;
          wcnt   = 0;
          cur_wr = ds_wr_en;
          if (ds_wr_en === 1'b1) begin
            dsw_cnt++;
            last_waddr = ds_addr;
            last_wdata = ds_wr_data;
          end else begin
            dsr_cnt++;
          end
        end
        if (busy) begin
          if (wcnt >= ack_dly) begin
            ds_ack_vld = 1'b1;
            if (cur_wr) mem[ds_addr] = ds_wr_data;
            else        ds_rd_data   = mem[ds_addr];
            busy = 1'b0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;   // negedges from request drive to ack observation
    int          t0;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (up_ack_vld === 1'b1) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: got data=%h err=%b, want no ack", up_rd_data, up_err);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (up_rd_data !== e.data || up_err !== e.err || (cyc - e.t0) != e.lat) begin
            n_fail++;
            $display("FAIL ack_check: got data=%h err=%b lat=%0d, want data=%h err=%b lat=%0d",
                     up_rd_data, up_err, cyc - e.t0, e.data, e.err, e.lat);
          end
        end
      end else begin
        n_tests++;
        if (up_rd_data !== 32'd0 || up_err !== 1'b0 || up_ack_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_outputs: got ack=%b data=%h err=%b, want 0/0/0", up_ack_vld, up_rd_data, up_err);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic e, input int lat);
    exp_t x;
    x.data = d; x.err = e; x.lat = lat; x.t0 = cyc;
    sbq.push_back(x);
  endtask

  // Must be called at a negedge: one-cycle request pulse.
  task automatic send(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] wd);
    up_req_vld = 1'b1; up_wr_en = wr; up_rd_en = rd; up_addr = a; up_wr_data = wd;
    @(negedge clk);
    up_req_vld = 1'b0; up_wr_en = 1'b0; up_rd_en = 1'b0; up_addr = 3'd0; up_wr_data = 32'd0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending acks, want 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic b_xact(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input int elat, input string name);
    int n;
    b_req = 1'b1; b_wr = wr; b_rd = rd; b_addr = a; b_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      b_req = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_addr = 3'd0; b_wdata = 32'd0;
      n++;
    end while (b_ack !== 1'b1 && n < 20);
    n_tests++;
    if (b_ack !== 1'b1 || b_rdata !== ed || b_err !== ee || n != elat) begin
      n_fail++;
      $display("FAIL %s: got ack=%b data=%h err=%b lat=%0d, want ack=1 data=%h err=%b lat=%0d",
               name, b_ack, b_rdata, b_err, n, ed, ee, elat);
    end
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         wr;
    logic         rd;
    logic [2:0]   addr;      // {entry, slice}
    logic [31:0]  wdata;
    int           dly;
    logic         pre;       // overwrite both memory entries before request
    logic [127:0] fill;
    logic [31:0]  exp_data;
    logic         exp_err;
    int           dsw;
    int           dsr;
    logic         chk;       // check committed downstream write
    logic [127:0] exp_wdata;
  } vec_t;

  localparam int NV = 21;
  localparam logic [127:0] ALLF = {128{1'b1}};
  localparam logic [127:0] AAAA = {32{4'hA}};
  localparam logic [127:0] FIVE = {32{4'h5}};
  localparam logic [127:0] M1   = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] Z    = 128'd0;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{1'b0,1'b1,3'b110,32'h0,        0,1'b0,Z,   32'h3333_3333,1'b0,0,1,1'b0,Z};
    vecs[1]  = '{1'b0,1'b1,3'b111,32'h0,        1,1'b0,Z,   32'h4444_4444,1'b0,0,0,1'b0,Z};
    vecs[2]  = '{1'b0,1'b1,3'b000,32'h0,        2,1'b0,Z,   32'hFFFF_FFFF,1'b0,0,1,1'b0,Z};
    vecs[3]  = '{1'b0,1'b1,3'b001,32'h0,        1,1'b1,AAAA,32'hFFFF_FFFF,1'b0,0,0,1'b0,Z};
    vecs[4]  = '{1'b0,1'b1,3'b010,32'h0,        1,1'b0,Z,   32'hFFFF_FFFF,1'b0,0,0,1'b0,Z};
    vecs[5]  = '{1'b0,1'b1,3'b011,32'h0,        1,1'b0,Z,   32'hFFFF_FFFF,1'b0,0,0,1'b0,Z};
    vecs[6]  = '{1'b1,1'b0,3'b111,32'hFFFF_FFFF,1,1'b0,Z,   32'h0,        1'b0,0,0,1'b0,Z};
    vecs[7]  = '{1'b1,1'b0,3'b110,32'hFFFF_FFFF,1,1'b0,Z,   32'h0,        1'b0,0,0,1'b0,Z};
    vecs[8]  = '{1'b1,1'b0,3'b101,32'hFFFF_FFFF,1,1'b0,Z,   32'h0,        1'b0,0,0,1'b0,Z};
    vecs[9]  = '{1'b1,1'b0,3'b100,32'hFFFF_FFFF,1,1'b1,FIVE,32'h0,        1'b0,1,0,1'b1,ALLF};
    vecs[10] = '{1'b0,1'b1,3'b010,32'h0,        1,1'b0,Z,   32'hFFFF_FFFF,1'b0,0,0,1'b0,Z};
    vecs[11] = '{1'b1,1'b0,3'b001,32'h0BAD_F00D,1,1'b0,Z,   32'h0,        1'b0,0,0,1'b0,Z};
    vecs[12] = '{1'b1,1'b0,3'b000,32'h1234_5678,1,1'b0,Z,   32'h0,        1'b0,1,0,1'b1,
                 128'hFFFF_FFFF_FFFF_FFFF_0BAD_F00D_1234_5678};
    vecs[13] = '{1'b0,1'b1,3'b001,32'h0,        1,1'b0,Z,   32'h0BAD_F00D,1'b0,0,1,1'b0,Z};
    vecs[14] = '{1'b0,1'b1,3'b010,32'h0,        1,1'b0,Z,   32'hFFFF_FFFF,1'b0,0,0,1'b0,Z};
    vecs[15] = '{1'b0,1'b1,3'b000,32'h0,        0,1'b0,Z,   32'h1234_5678,1'b0,0,1,1'b0,Z};
    vecs[16] = '{1'b0,1'b0,3'b011,32'h0,        1,1'b0,Z,   32'h0,        1'b0,0,0,1'b0,Z};
    vecs[17] = '{1'b1,1'b1,3'b111,32'h7777_7777,1,1'b0,Z,   32'h0,        1'b0,0,0,1'b0,Z};
    vecs[18] = '{1'b1,1'b0,3'b100,32'h0000_0001,0,1'b0,Z,   32'h0,        1'b0,1,0,1'b1,
                 128'h7777_7777_FFFF_FFFF_0BAD_F00D_0000_0001};
    vecs[19] = '{1'b0,1'b1,3'b011,32'h0,        1,1'b0,Z,   32'hFFFF_FFFF,1'b0,0,0,1'b0,Z};
    vecs[20] = '{1'b1,1'b0,3'b000,32'hAAAA_0000,1,1'b0,Z,   32'h0,        1'b0,1,0,1'b1,
                 128'h7777_7777_FFFF_FFFF_0BAD_F00D_AAAA_0000};

    mem[0] = ALLF;
    mem[1] = M1;

    // Reset state of both DUTs.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({up_ack_vld, up_rd_data, up_err, ds_req_vld, ds_wr_en, ds_rd_en, ds_addr, ds_wr_data,
         b_ack, b_rdata, b_err, b_ds_req, b_ds_wr, b_ds_rd, b_ds_addr, b_ds_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b data=%h ds_req=%b ds_wdata=%h, want all 0",
               up_ack_vld, up_rd_data, ds_req_vld, ds_wr_data);
    end
    rstn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Table-driven sequence.
    for (int i = 0; i < NV; i++) begin
      int w0, r0, lat;
      if (vecs[i].pre) begin
        mem[0] = vecs[i].fill;
        mem[1] = vecs[i].fill;
      end
      ack_dly = vecs[i].dly;
      w0 = dsw_cnt;
      r0 = dsr_cnt;
      lat = (vecs[i].dsw + vecs[i].dsr > 0) ? 2 + vecs[i].dly : 1;
      push_exp(vecs[i].exp_data, vecs[i].exp_err, lat);
      send(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      drain($sformatf("vec%0d", i));
      n_tests++;
      if (dsw_cnt - w0 != vecs[i].dsw || dsr_cnt - r0 != vecs[i].dsr) begin
        n_fail++;
        $display("FAIL vec%0d_ds_ops: got wr=%0d rd=%0d, want wr=%0d rd=%0d",
                 i, dsw_cnt - w0, dsr_cnt - r0, vecs[i].dsw, vecs[i].dsr);
      end
      if (vecs[i].chk) begin
        n_tests++;
        if (last_waddr !== vecs[i].addr[2] || last_wdata !== vecs[i].exp_wdata) begin
          n_fail++;
          $display("FAIL vec%0d_commit: got addr=%0d data=%h, want addr=%0d data=%h",
                   i, last_waddr, last_wdata, vecs[i].addr[2], vecs[i].exp_wdata);
        end
      end
    end

    // Timeout on a read of entry 0 (snapshot invalidated by vec20).
    begin
      int r0;
      ack_off = 1'b1;
      r0 = dsr_cnt;
      push_exp(32'hDEAD_BEEF, 1'b1, 9);
      send(1'b0, 1'b1, 3'b001, 32'h0);
      drain("timeout");
      n_tests++;
      if (dsr_cnt - r0 != 1) begin
        n_fail++;
        $display("FAIL timeout_ds_rd: got %0d reads, want 1", dsr_cnt - r0);
      end
      // Snapshot must still be invalid: this read has to go downstream.
      ack_off = 1'b0;
      ack_dly = 1;
      r0 = dsr_cnt;
      push_exp(32'h7777_7777, 1'b0, 3);
      send(1'b0, 1'b1, 3'b011, 32'h0);
      drain("post_timeout_read");
      n_tests++;
      if (dsr_cnt - r0 != 1) begin
        n_fail++;
        $display("FAIL post_timeout_miss: got %0d reads, want 1", dsr_cnt - r0);
      end
    end

    // Reset in the middle of a downstream write.
    begin
      int w0;
      push_exp(32'h0, 1'b0, 1);
      send(1'b1, 1'b0, 3'b101, 32'h9999_9999);
      drain("buffer_before_reset");
      ack_off = 1'b1;
      send(1'b1, 1'b0, 3'b100, 32'h1357_9BDF);
      n_tests++;
      if (ds_req_vld !== 1'b1 || ds_wr_en !== 1'b1 || ds_addr !== 1'b1 ||
          ds_wr_data !== 128'h7777_7777_FFFF_FFFF_9999_9999_1357_9BDF) begin
        n_fail++;
        $display("FAIL ds_wr_pulse: got req=%b wr=%b addr=%0d data=%h, want 1/1/1/%h",
                 ds_req_vld, ds_wr_en, ds_addr, ds_wr_data,
                 128'h7777_7777_FFFF_FFFF_9999_9999_1357_9BDF);
      end
      rstn = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({up_ack_vld, up_rd_data, up_err, ds_req_vld, ds_wr_en, ds_rd_en, ds_addr, ds_wr_data} !== '0) begin
        n_fail++;
        $display("FAIL midreset_outputs: got ack=%b ds_req=%b addr=%0d wdata=%h, want all 0",
                 up_ack_vld, ds_req_vld, ds_addr, ds_wr_data);
      end
      @(negedge clk);
      rstn = 1'b1;
      ack_off = 1'b0;
      repeat (12) @(negedge clk);
      w0 = dsw_cnt;
      ack_dly = 1;
      push_exp(32'h0, 1'b0, 3);
      send(1'b1, 1'b0, 3'b100, 32'h5555_5555);
      drain("post_reset_commit");
      n_tests++;
      if (dsw_cnt - w0 != 1 || last_waddr !== 1'b1 || last_wdata !== 128'h0000_0000_0000_0000_0000_0000_5555_5555) begin
        n_fail++;
        $display("FAIL post_reset_commit_data: got n=%0d addr=%0d data=%h, want 1/1/%h",
                 dsw_cnt - w0, last_waddr, last_wdata, 128'h5555_5555);
      end
    end

    // Error slice on the 3-slice instance.
    begin
      int c0;
      c0 = b_dsreq_cnt;
      b_xact(1'b0, 1'b1, 3'b011, 32'h0,         32'hDEAD_BEEF, 1'b1, 1, "b_bad_slice_rd");
      b_xact(1'b1, 1'b0, 3'b111, 32'h1111_2222, 32'hDEAD_BEEF, 1'b1, 1, "b_bad_slice_wr");
      n_tests++;
      if (b_dsreq_cnt != c0) begin
        n_fail++;
        $display("FAIL b_bad_slice_ds: got %0d ds requests, want 0", b_dsreq_cnt - c0);
      end
      c0 = b_dsreq_cnt;
      b_xact(1'b0, 1'b1, 3'b110, 32'h0, 32'hCCCC_0002, 1'b0, 2, "b_zero_wait_read");
      b_xact(1'b0, 1'b1, 3'b101, 32'h0, 32'hBBBB_0001, 1'b0, 1, "b_snapshot_hit");
      n_tests++;
      if (b_dsreq_cnt - c0 != 1) begin
        n_fail++;
        $display("FAIL b_read_ds: got %0d ds requests, want 1", b_dsreq_cnt - c0);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
